// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit: condition codes, FSM encoding,
// flag bit positions (also used by the ALU) and the next-PC helper.
package branch_resolve_unit_pkg;

    localparam logic [2:0] COND_BE  = 3'b000;
    localparam logic [2:0] COND_BLT = 3'b001;
    localparam logic [2:0] COND_BLE = 3'b010;
    localparam logic [2:0] COND_BNE = 3'b011;
    localparam logic [2:0] COND_B   = 3'b100;
    localparam logic [2:0] COND_BGE = 3'b101;
    localparam logic [2:0] COND_BGT = 3'b110;
    localparam logic [2:0] COND_BCS = 3'b111;

    localparam int FLAG_S = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // Sequential PC is pc+1; a taken branch adds the sign-extended displacement on top.
    function automatic logic [15:0] next_pc(input logic [15:0] pc, input logic [7:0] disp,
                                            input logic taken);
        logic [15:0] seq_pc;
        seq_pc = pc + 16'd1;
        return taken ? seq_pc + {{8{disp[7]}}, disp} : seq_pc;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_cond_eval.sv
// Combinational condition-code evaluation against an SZCV flag vector.
module branch_cond_eval
    import branch_resolve_unit_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [3:0] szcv,
    output logic       taken
);

    logic s, z, c, v, lt;

    always_comb begin
        s     = szcv[FLAG_S];
        z     = szcv[FLAG_Z];
        c     = szcv[FLAG_C];
        v     = szcv[FLAG_V];
        lt    = s ^ v;
        taken = 1'b0;
        case (cond)
            COND_BE:  taken = z;
            COND_BLT: taken = lt;
            COND_BLE: taken = z | lt;
            COND_BNE: taken = ~z;
            COND_B:   taken = 1'b1;
            COND_BGE: taken = ~lt;
            COND_BGT: taken = ~z & ~lt;
            COND_BCS: taken = c;
            default:  taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves conditional branches against the SZCV register, forwarding same-cycle
// ALU flag writes and stalling while a flag-writing operation is still in flight.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flag_we,
    input  logic [3:0]  szcv_in,
    input  logic        flag_pending,
    input  logic        br_valid,
    output logic        br_ready,
    input  logic [2:0]  br_cond,
    input  logic [7:0]  br_disp,
    input  logic [15:0] br_pc,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        res_taken,
    output logic [15:0] res_target,
    output logic [3:0]  flags
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // the sender holds its payload stable while valid=1 and ready=0.

    state_t      state_q;
    logic [3:0]  flags_q;
    logic [2:0]  cond_q;
    logic [7:0]  disp_q;
    logic [15:0] pc_q;

    logic [2:0]  eval_cond;
    logic [7:0]  eval_disp;
    logic [15:0] eval_pc;
    logic [3:0]  eff_flags;
    logic        eval_taken;
    logic [15:0] eval_target;

    // In IDLE the live request is evaluated; in WAIT the captured one is.
    always_comb begin
        eval_cond = cond_q;
        eval_disp = disp_q;
        eval_pc   = pc_q;
        if (state_q == ST_IDLE) begin
            eval_cond = br_cond;
            eval_disp = br_disp;
            eval_pc   = br_pc;
        end
    end

    assign eff_flags = flag_we ? szcv_in : flags_q;

    branch_cond_eval u_cond_eval (
        .cond  (eval_cond),
        .szcv  (eff_flags),
        .taken (eval_taken)
    );

    assign eval_target = next_pc(eval_pc, eval_disp, eval_taken);
    assign flags       = flags_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            flags_q    <= 4'b0000;
            cond_q     <= 3'b000;
            disp_q     <= 8'h00;
            pc_q       <= 16'h0000;
            br_ready   <= 1'b1;
            res_valid  <= 1'b0;
            res_taken  <= 1'b0;
            res_target <= 16'h0000;
        end else begin
            if (flag_we) begin
                flags_q <= szcv_in;
            end
            case (state_q)
                ST_IDLE: begin
                    if (br_valid) begin
                        cond_q   <= br_cond;
                        disp_q   <= br_disp;
                        pc_q     <= br_pc;
                        br_ready <= 1'b0;
                        // Unconditional branches never depend on flags, so they skip the stall.
                        if (flag_pending && (br_cond != COND_B)) begin
                            state_q <= ST_WAIT;
                        end else begin
                            res_taken  <= eval_taken;
                            res_target <= eval_target;
                            res_valid  <= 1'b1;
                            state_q    <= ST_RESP;
                        end
                    end
                end
                ST_WAIT: begin
                    if (flag_we) begin
                        res_taken  <= eval_taken;
                        res_target <= eval_target;
                        res_valid  <= 1'b1;
                        state_q    <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        br_ready  <= 1'b1;
                        state_q   <= ST_IDLE;
                    end
                end
                default: begin
                    res_valid <= 1'b0;
                    br_ready  <= 1'b1;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port flag_we, input, 1 bit: the ALU is writing flags this cycle.
REQ-004 SHALL have port szcv_in, input, 4 bits: flags from the ALU, where [3]=S, [2]=Z, [1]=C and [0]=V.
REQ-005 SHALL have port flag_pending, input, 1 bit: a flag-writing ALU operation is in flight and has not yet asserted flag_we.
REQ-006 SHALL have port br_valid, input, 1 bit: a branch request is presented.
REQ-007 SHALL have port br_ready, output, 1 bit: the unit can accept a request.
REQ-008 SHALL have port br_cond, input, 3 bits: the condition code, encoded per REQ-016.
REQ-009 SHALL have port br_disp, input, 8 bits: the signed displacement.
REQ-010 SHALL have port br_pc, input, 16 bits: the PC of the branch instruction.
REQ-011 SHALL have port res_valid, output, 1 bit: a resolved branch is presented.
REQ-012 SHALL have port res_ready, input, 1 bit: the consumer accepts the result.
REQ-013 SHALL have port res_taken, output, 1 bit: the branch is taken.
REQ-014 SHALL have port res_target, output, 16 bits: the next PC.
REQ-015 SHALL have port flags, output, 4 bits: the current architectural SZCV register.

Function
REQ-016 SHALL map condition codes to taken conditions as follows:
- 000 BE: Z
- 001 BLT: S^V
- 010 BLE: Z|(S^V)
- 011 BNE: !Z
- 100 B: 1
- 101 BGE: !(S^V)
- 110 BGT: !Z & !(S^V)
- 111 BCS: C
REQ-017 SHALL load the flags register from szcv_in on every clock edge where flag_we=1, in any FSM state.
REQ-018 SHALL compute effective flags as szcv_in when flag_we=1, and as the flags register otherwise (write-through forwarding).
REQ-019 SHALL use an FSM with states IDLE, WAIT, RESP, and SHALL drive br_ready=1 only in IDLE.
REQ-020 SHALL accept a request on an edge where br_valid and br_ready are both 1, capturing br_cond, br_disp and br_pc.
REQ-021 SHALL, on acceptance with flag_pending=1 and br_cond!=100, go to WAIT.
REQ-022 SHALL, on any other acceptance, evaluate the condition on the effective flags, register res_taken and res_target, and go to RESP; latency is therefore 1 cycle.
REQ-023 SHALL, in WAIT, on the first edge where flag_we=1, evaluate the condition on szcv_in, register the result and go to RESP; with flag_we=0 it SHALL stay in WAIT indefinitely.
REQ-024 SHALL, in WAIT, ignore the flag_pending level; only flag_we ends the wait.
REQ-025 SHALL assert res_valid only in RESP, holding res_taken and res_target stable until res_ready=1.
REQ-026 SHALL return to IDLE from RESP on the edge where res_ready=1, so that the next request is accepted no earlier than the following edge (at most one branch per 2 cycles).
REQ-027 SHALL set res_target, when taken, to br_pc + 1 + sign_extend(br_disp), truncated to 16 bits so that wrap-around is modulo 2^16.
REQ-028 SHALL set res_target, when not taken, to br_pc + 1 modulo 2^16; pc=16'hFFFF therefore gives 16'h0000.
REQ-029 SHALL leave res_taken and res_target at their last values when res_valid=0.

Reset
REQ-030 SHALL, while rst_n=0, drive:
- FSM state = IDLE
- flags = 4'b0000
- res_valid = 0
- res_taken = 0
- res_target = 16'h0000
- br_ready = 1 after deassertion
REQ-031 SHALL, when reset asserts in WAIT or RESP, abort the in-flight branch; no result appears after reset.
REQ-032 SHALL ignore flag_we and br_valid while rst_n=0.

Structure
REQ-033 SHALL place in a shared package:
- the condition-code constants
- the FSM state encoding
- the flag bit indices S=3, Z=2, C=1, V=0, shared with the ALU
REQ-034 SHALL place the condition evaluation in one combinational sub-module, branch_cond_eval (inputs cond[2:0] and szcv[3:0]; output taken).
REQ-035 SHALL use only the one clock domain.

Verification
REQ-036 SHALL cover forwarding: flag_we=1 with szcv_in=0100 in the same cycle as accepting BE (pc=16'h0010, disp=8'h05) -> res_valid at the next edge, taken=1, target=16'h0016.
REQ-037 SHALL cover the hazard wait: flag_pending=1, accept BLT (pc=16'h0100, disp=8'hFE), flag_we 3 cycles later with szcv_in=1000 -> stays in WAIT 3 cycles, then taken=1, target=16'h00FF.
REQ-038 SHALL cover unconditional branch under hazard: flag_pending=1, B (pc=16'h0000, disp=8'h80) -> no wait, taken=1, target=16'hFF81.
REQ-039 SHALL cover backpressure and wrap: BNE with flags=0100 at pc=16'hFFFF, res_ready held 0 for 4 cycles -> res_valid held, taken=0, target=16'h0000, br_ready=0 throughout.
REQ-040 SHALL cover reset mid-operation: assert rst_n=0 while in WAIT -> res_valid=0, flags=0000, br_ready=1 after release, and no stale result later.
REQ-041 SHALL cover a sweep of all 8 conditions against all 16 flag values, comparing against a reference model.
